// File: rtl/instr_prefetch.sv
// Byte-serial Y86-64 instruction fetch front end.
//
// Reads one instruction byte per imem handshake, assembles a whole
// instruction (1, 2, 9 or 10 bytes) and offers the decoded fields to decode
// over a valid/ready handshake. Halt, invalid icode and memory/address faults
// park the unit in STOP until a PC redirect arrives.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   redirect_valid, redirect_pc  load a new fetch PC; beats every other event
//   imem_req, imem_addr          byte read request / address (held until ack)
//   imem_ack, imem_rdata,        read completion, data byte, fault flag
//   imem_err
//   out_valid, out_ready         instruction handshake toward decode
//   icode, ifun, rA, rB, valC,   decoded instruction fields
//   valP
//   instr_valid, imem_error, hlt instruction status flags
module instr_prefetch #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        imem_error,
  output logic        hlt
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  typedef enum logic [1:0] {S_FETCH, S_OUT, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        drain_q, drain_d;
  logic [63:0] drain_addr_q, drain_addr_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;
  logic        iv_q, iv_d, err_q, err_d, hlt_q, hlt_d;

  logic [63:0] fetch_addr;
  logic        addr_bad;
  logic [3:0]  cur_ic;
  logic [3:0]  cur_len;
  logic [3:0]  byte_idx;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  assign fetch_addr = pc_q + {60'd0, cnt_q};
  assign addr_bad   = (fetch_addr >= MEM_LIMIT);

  // A drain is the leftover read from before a redirect; it keeps the old
  // address on the bus until acked and its byte is thrown away.
  assign imem_req  = !rst && (drain_q || (state_q == S_FETCH && !addr_bad));
  assign imem_addr = drain_q ? drain_addr_q : fetch_addr;

  // icode is only in a register after byte 0; for byte 0 use the bus.
  assign cur_ic  = (cnt_q == 4'd0) ? imem_rdata[7:4] : icode_q;
  assign cur_len = instr_len(cur_ic);
  // Position of this byte inside valC: 7/8 carry valC from byte 1, 3/4/5 from byte 2.
  assign byte_idx = (cur_ic == 4'h7 || cur_ic == 4'h8) ? cnt_q - 4'd1 : cnt_q - 4'd2;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    drain_addr_d = drain_addr_q;
    icode_d      = icode_q;
    ifun_d       = ifun_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    valc_d       = valc_q;
    valp_d       = valp_q;
    iv_d         = iv_q;
    err_d        = err_q;
    hlt_d        = hlt_q;

    if (redirect_valid) begin
      state_d      = S_FETCH;
      pc_d         = redirect_pc;
      cnt_d        = 4'd0;
      drain_d      = imem_req && !imem_ack;
      drain_addr_d = imem_addr;
      icode_d      = 4'h0;
      ifun_d       = 4'h0;
      ra_d         = 4'hF;
      rb_d         = 4'hF;
      valc_d       = 64'd0;
      valp_d       = 64'd0;
      iv_d         = 1'b1;
      err_d        = 1'b0;
      hlt_d        = 1'b0;
    end else begin
      if (drain_q && imem_ack) drain_d = 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!drain_q) begin
            if (addr_bad) begin
              state_d = S_OUT;
              err_d   = 1'b1;
              hlt_d   = 1'b0;
              valp_d  = pc_q;
            end else if (imem_ack) begin
              if (imem_err) begin
                state_d = S_OUT;
                err_d   = 1'b1;
                hlt_d   = 1'b0;
                valp_d  = pc_q;
              end else begin
                if (cnt_q == 4'd0) begin
                  icode_d = imem_rdata[7:4];
                  ifun_d  = imem_rdata[3:0];
                end else if (cnt_q == 4'd1 && has_regs(cur_ic)) begin
                  ra_d = imem_rdata[7:4];
                  rb_d = imem_rdata[3:0];
                end else begin
                  valc_d[{byte_idx[2:0], 3'b000} +: 8] = imem_rdata;
                end
                if (cnt_q == cur_len - 4'd1) begin
                  state_d = S_OUT;
                  valp_d  = pc_q + {60'd0, cur_len};
                  hlt_d   = (cur_ic == 4'h0);
                  iv_d    = (cur_ic <= 4'hB);
                end else begin
                  cnt_d = cnt_q + 4'd1;
                end
              end
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_d = (hlt_q || !iv_q || err_q) ? S_STOP : S_FETCH;
            pc_d    = valp_q;
            cnt_d   = 4'd0;
            icode_d = 4'h0;
            ifun_d  = 4'h0;
            ra_d    = 4'hF;
            rb_d    = 4'hF;
            valc_d  = 64'd0;
            valp_d  = 64'd0;
            iv_d    = 1'b1;
            err_d   = 1'b0;
            hlt_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      cnt_q        <= 4'd0;
      drain_q      <= 1'b0;
      drain_addr_q <= 64'd0;
      icode_q      <= 4'h0;
      ifun_q       <= 4'h0;
      ra_q         <= 4'hF;
      rb_q         <= 4'hF;
      valc_q       <= 64'd0;
      valp_q       <= 64'd0;
      iv_q         <= 1'b1;
      err_q        <= 1'b0;
      hlt_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      drain_addr_q <= drain_addr_d;
      icode_q      <= icode_d;
      ifun_q       <= ifun_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      valc_q       <= valc_d;
      valp_q       <= valp_d;
      iv_q         <= iv_d;
      err_q        <= err_d;
      hlt_q        <= hlt_d;
    end
  end

  assign out_valid   = (state_q == S_OUT);
  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = valc_q;
  assign valP        = valp_q;
  assign instr_valid = iv_q;
  assign imem_error  = err_q;
  assign hlt         = hlt_q;

endmodule

// File: tb/tb_instr_prefetch.sv
// Testbench for instr_prefetch: byte memory responder with programmable ack
// latency and fault injection, directed scenarios, and a randomized stream of
// instructions checked against a field-level instruction model.
module tb_instr_prefetch;

  localparam int MEMB = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        imem_err;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_valid, imem_error, hlt;

  logic [7:0]  mem [0:MEMB-1];
  int          wcnt;
  int          ack_dly;
  int          fixed_dly;
  bit          rand_dly;
  bit          err_en;
  logic [63:0] err_addr;
  logic [63:0] req_log[$];

  int checks   = 0;
  int failures = 0;

  instr_prefetch #(.RESET_PC(64'd0), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error), .hlt(hlt)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_ack   = imem_req && (wcnt >= ack_dly);
    imem_rdata = (imem_addr < 64'(MEMB)) ? mem[imem_addr[9:0]] : 8'h00;
    imem_err   = err_en && (imem_addr == err_addr);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= 0;
      ack_dly <= fixed_dly;
    end else if (imem_req && imem_ack) begin
      req_log.push_back(imem_addr);
      wcnt    <= 0;
      ack_dly <= rand_dly ? int'($urandom_range(0, 2)) : fixed_dly;
    end else if (imem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    repeat (2) @(negedge clk);
    req_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < MEMB; i++) mem[i] = 8'h00;
  endtask

  function automatic int ilen(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 1;
    endcase
  endfunction

  // Field-level view of the instruction stored at pc (in-range, fault-free).
  task automatic model(input logic [63:0] pc, output logic [3:0] ic, output logic [3:0] fn,
                       output logic [3:0] ra, output logic [3:0] rb,
                       output logic [63:0] vc, output logic [63:0] vp);
    int off;
    ic = mem[pc[9:0]][7:4];
    fn = mem[pc[9:0]][3:0];
    ra = 4'hF;
    rb = 4'hF;
    vc = 64'd0;
    off = 0;
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
      ra = mem[pc[9:0] + 10'd1][7:4];
      rb = mem[pc[9:0] + 10'd1][3:0];
    end
    if (ic inside {4'h7, 4'h8}) off = 1;
    if (ic inside {4'h3, 4'h4, 4'h5}) off = 2;
    if (off != 0)
      for (int j = 0; j < 8; j++) vc[8*j +: 8] = mem[pc[9:0] + 10'(off + j)];
    vp = pc + 64'(ilen(ic));
  endtask

  initial begin
    int cyc;
    logic [3:0]  e_ic, e_fn, e_ra, e_rb;
    logic [63:0] e_vc, e_vp, pc;

    fixed_dly = 0; rand_dly = 0; err_en = 0; err_addr = 64'd0;
    mem_clear();

    // Reset values
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rArB", {56'd0, rA, rB}, 64'hFF);
    chk("rst_icode", {56'd0, icode, ifun}, 64'd0);
    chk("rst_valC", valC, 64'd0);
    chk("rst_valP", valP, 64'd0);
    chk("rst_flags", {61'd0, instr_valid, imem_error, hlt}, 64'b100);

    // irmovq $10,%rbx with ack tied high
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
    do_reset();
    wait_out("irmov", cyc);
    chk("irmov_cycles", 64'(cyc), 64'd10);
    chk("irmov_icode", {56'd0, icode, ifun}, 64'h30);
    chk("irmov_rArB", {56'd0, rA, rB}, 64'hF3);
    chk("irmov_valC", valC, 64'd10);
    chk("irmov_valP", valP, 64'd10);

    // jmp 0x20 with decode stalling 3 cycles
    mem_clear();
    mem[0] = 8'h70; mem[1] = 8'h20;
    do_reset();
    wait_out("jmp", cyc);
    for (int i = 0; i < 3; i++) begin
      chk("jmp_hold_valid", 64'(out_valid), 64'd1);
      chk("jmp_hold_valC", valC, 64'h20);
      chk("jmp_hold_valP", valP, 64'd9);
      chk("jmp_hold_rArB", {56'd0, rA, rB}, 64'hFF);
      chk("jmp_hold_req", 64'(imem_req), 64'd0);
      @(negedge clk);
    end
    accept();
    chk("jmp_next_valid", 64'(out_valid), 64'd0);
    chk("jmp_next_req", 64'(imem_req), 64'd1);
    chk("jmp_next_addr", imem_addr, 64'd9);

    // halt, stop, redirect out of STOP
    mem_clear();
    mem[64] = 8'h10;
    do_reset();
    wait_out("halt", cyc);
    chk("halt_hlt", 64'(hlt), 64'd1);
    chk("halt_valP", valP, 64'd1);
    accept();
    repeat (3) begin
      chk("halt_stop_req", 64'(imem_req), 64'd0);
      chk("halt_stop_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redir_req", 64'(imem_req), 64'd1);
    chk("redir_addr", imem_addr, 64'h40);
    wait_out("redir", cyc);
    chk("redir_nop", {56'd0, icode, ifun}, 64'h10);
    chk("redir_valP", valP, 64'h41);
    chk("redir_hlt", 64'(hlt), 64'd0);

    // Invalid icode
    mem_clear();
    mem[0] = 8'hF0;
    do_reset();
    wait_out("inv", cyc);
    chk("inv_iv", 64'(instr_valid), 64'd0);
    chk("inv_valP", valP, 64'd1);
    accept();
    @(negedge clk);
    chk("inv_stop_req", 64'(imem_req), 64'd0);
    chk("inv_stop_valid", 64'(out_valid), 64'd0);

    // Memory fault on byte 1 of pushq-class instruction
    mem_clear();
    mem[0] = 8'h60; mem[1] = 8'h12;
    err_en = 1; err_addr = 64'd1;
    do_reset();
    wait_out("merr", cyc);
    chk("merr_err", 64'(imem_error), 64'd1);
    chk("merr_valP", valP, 64'd0);
    chk("merr_icode", {56'd0, icode}, 64'h6);
    accept();
    @(negedge clk);
    chk("merr_stop_req", 64'(imem_req), 64'd0);
    err_en = 0;

    // Redirect while a slow read is outstanding
    mem_clear();
    mem[0] = 8'h10; mem[128] = 8'h20; mem[129] = 8'h34;
    fixed_dly = 4;
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("stale_req", 64'(imem_req), 64'd1);
    chk("stale_addr", imem_addr, 64'd0);
    wait_out("stale", cyc);
    chk("stale_icode", {56'd0, icode, ifun}, 64'h20);
    chk("stale_rArB", {56'd0, rA, rB}, 64'h34);
    chk("stale_valP", valP, 64'h82);
    chk("stale_log_n", 64'(req_log.size()), 64'd3);
    if (req_log.size() == 3) begin
      chk("stale_log0", req_log[0], 64'd0);
      chk("stale_log1", req_log[1], 64'h80);
      chk("stale_log2", req_log[2], 64'h81);
    end
    fixed_dly = 0;

    // irmovq straddling the end of memory
    mem_clear();
    mem[MEMB-5] = 8'h30; mem[MEMB-4] = 8'hF3; mem[MEMB-3] = 8'h07;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 64'(MEMB - 5);
    @(negedge clk);
    redirect_valid = 1'b0;
    req_log.delete();
    wait_out("oob", cyc);
    chk("oob_err", 64'(imem_error), 64'd1);
    chk("oob_valP", valP, 64'(MEMB - 5));
    chk("oob_fields", {48'd0, icode, ifun, rA, rB}, 64'h30F3);
    chk("oob_valC", valC, 64'h07);
    repeat (3) @(negedge clk);
    chk("oob_req", 64'(imem_req), 64'd0);
    chk("oob_log_n", 64'(req_log.size()), 64'd5);
    if (req_log.size() != 0) chk("oob_log0", req_log[0], 64'(MEMB - 5));

    // Randomized instruction stream, random ack latency and decode stalls
    mem_clear();
    pc = 64'd0;
    while (pc < 64'd900) begin
      logic [3:0] ic;
      int n;
      ic = 4'($urandom_range(1, 11));
      n = ilen(ic);
      mem[pc[9:0]] = {ic, 4'($urandom_range(0, 15))};
      for (int k = 1; k < n; k++) mem[pc[9:0] + 10'(k)] = 8'($urandom);
      pc = pc + 64'(n);
    end
    rand_dly = 1;
    do_reset();
    pc = 64'd0;
    for (int n = 0; n < 40; n++) begin
      wait_out("rnd", cyc);
      model(pc, e_ic, e_fn, e_ra, e_rb, e_vc, e_vp);
      chk("rnd_fields", {48'd0, icode, ifun, rA, rB}, {48'd0, e_ic, e_fn, e_ra, e_rb});
      chk("rnd_valC", valC, e_vc);
      chk("rnd_valP", valP, e_vp);
      chk("rnd_flags", {61'd0, instr_valid, imem_error, hlt}, 64'b100);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      accept();
      pc = e_vp;
    end
    rand_dly = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
